// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM arbiter between the program loader and the CPU.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam logic REQ_LOADER = 1'b0;
    localparam logic REQ_CPU    = 1'b1;

    // Holds RD_LATENCY-1, so 3 bits cover latencies 1..8.
    localparam int LAT_CNT_W = 3;

    localparam int STAT_W = 16;

    // Increment by one when enabled, sticking at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating grant and conflict counters for the RAM arbiter (built only with MEM_ARB_STATS_EN).
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        gnt,
    input  logic              conflict,
    output logic [STAT_W-1:0] gnt_count0,
    output logic [STAT_W-1:0] gnt_count1,
    output logic [STAT_W-1:0] conflict_count
);

    logic [STAT_W-1:0] gnt_count0_q, gnt_count0_d;
    logic [STAT_W-1:0] gnt_count1_q, gnt_count1_d;
    logic [STAT_W-1:0] conflict_count_q, conflict_count_d;

    // Next counter values: bump on each event, hold at full scale.
    always_comb begin
        gnt_count0_d     = sat_inc(gnt_count0_q, gnt[0]);
        gnt_count1_d     = sat_inc(gnt_count1_q, gnt[1]);
        conflict_count_d = sat_inc(conflict_count_q, conflict);
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_count0_q     <= '0;
            gnt_count1_q     <= '0;
            conflict_count_q <= '0;
        end else begin
            gnt_count0_q     <= gnt_count0_d;
            gnt_count1_q     <= gnt_count1_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign gnt_count0     = gnt_count0_q;
    assign gnt_count1     = gnt_count1_q;
    assign conflict_count = conflict_count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port system RAM between the loader (0) and the CPU (1).
// One transaction in flight at a time; reads wait RD_LATENCY cycles for ram_rdata.
// Define MEM_ARB_STATS_EN to add the grant/conflict counter outputs.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          write,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                ram_en,
    output logic                ram_write,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   gnt_count0,
    output logic [STAT_W-1:0]   gnt_count1,
    output logic [STAT_W-1:0]   conflict_count
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LATENCY - 1);

    state_t                 state_q, state_d;
    // Also identifies the owner of the transaction in flight.
    logic                   last_winner_q, last_winner_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ram_en_q, ram_en_d;
    logic                   ram_write_q, ram_write_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
    logic                   winner;

    // Pick the requester to serve: a lone requester wins, a tie goes to the one that did not win last.
    always_comb begin
        if (req == 2'b01) begin
            winner = REQ_LOADER;
        end else if (req == 2'b10) begin
            winner = REQ_CPU;
        end else begin
            winner = ~last_winner_q;
        end
    end

    // Next-state and output logic for the IDLE -> ISSUE -> (RD_WAIT) sequence.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        last_winner_d = last_winner_q;
        lat_cnt_d     = lat_cnt_q;
        gnt_d         = '0;
        rvalid_d      = '0;
        rdata_d       = rdata_q;
        ram_en_d      = 1'b0;
        ram_write_d   = ram_write_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    ram_en_d      = 1'b1;
                    ram_write_d   = write[winner];
                    ram_addr_d    = (winner == REQ_CPU) ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
                    ram_wdata_d   = (winner == REQ_CPU) ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
                    gnt_d         = (winner == REQ_CPU) ? 2'b10 : 2'b01;
                    last_winner_d = winner;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (ram_write_q) begin
                    state_d = IDLE;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rdata_d  = ram_rdata;
                    rvalid_d = (last_winner_q == REQ_CPU) ? 2'b10 : 2'b01;
                    state_d  = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_winner_q <= REQ_CPU;
            lat_cnt_q     <= '0;
            gnt_q         <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            ram_en_q      <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            lat_cnt_q     <= lat_cnt_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            ram_en_q      <= ram_en_d;
            ram_write_q   <= ram_write_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clock          (clock),
        .reset          (reset),
        .gnt            (gnt_q),
        .conflict       ((state_q == IDLE) && (req == 2'b11)),
        .gnt_count0     (gnt_count0),
        .gnt_count1     (gnt_count1),
        .conflict_count (conflict_count)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic            clock;
    logic            reset;
    logic [1:0]      req       [2];
    logic [1:0]      write     [2];
    logic [2*AW-1:0] addr      [2];
    logic [2*DW-1:0] wdata     [2];
    logic [1:0]      gnt       [2];
    logic [1:0]      rvalid    [2];
    logic [DW-1:0]   rdata     [2];
    logic            ram_en    [2];
    logic            ram_write [2];
    logic [AW-1:0]   ram_addr  [2];
    logic [DW-1:0]   ram_wdata [2];
    logic [DW-1:0]   ram_rdata [2];
`ifdef MEM_ARB_STATS_EN
    logic [15:0]     gnt_count0     [2];
    logic [15:0]     gnt_count1     [2];
    logic [15:0]     conflict_count [2];
`endif

    int total = 0;
    int bad   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut0 (
        .clock(clock), .reset(reset), .req(req[0]), .write(write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]),
        .rdata(rdata[0]), .ram_en(ram_en[0]), .ram_write(ram_write[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
`ifdef MEM_ARB_STATS_EN
        , .gnt_count0(gnt_count0[0]), .gnt_count1(gnt_count1[0]), .conflict_count(conflict_count[0])
`endif
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(4)) dut1 (
        .clock(clock), .reset(reset), .req(req[1]), .write(write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]),
        .rdata(rdata[1]), .ram_en(ram_en[1]), .ram_write(ram_write[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
`ifdef MEM_ARB_STATS_EN
        , .gnt_count0(gnt_count0[1]), .gnt_count1(gnt_count1[1]), .conflict_count(conflict_count[1])
`endif
    );

    // RAM models: read data appears L rising edges after the ram_en cycle.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int L = (g == 0) ? 1 : 4;
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [L];
        always @(posedge clock) begin
            if (ram_en[g] && ram_write[g]) mem[ram_addr[g][7:0]] <= ram_wdata[g];
            pipe[0] <= (ram_en[g] && !ram_write[g]) ? mem[ram_addr[g][7:0]] : 16'hDEAD;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[g] = pipe[L-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g [8];
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = '0; write[i] = '0; addr[i] = '0; wdata[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check("rst_gnt", gnt[i], 2'b00);
            check("rst_rvalid", rvalid[i], 2'b00);
            check("rst_ram_en", ram_en[i], 1'b0);
            check("rst_ram_write", ram_write[i], 1'b0);
            check("rst_ram_addr", ram_addr[i], 16'h0);
            check("rst_rdata", rdata[i], 16'h0);
        end
        reset = 1'b1;
        @(negedge clock);

        // Loader write 0004 <- BEEF, granted one cycle after req
        req[0] = 2'b01; write[0] = 2'b01; addr[0][15:0] = 16'h0004; wdata[0][15:0] = 16'hBEEF;
        @(negedge clock);
        check("wr_gnt", gnt[0], 2'b01);
        check("wr_ram_en", ram_en[0], 1'b1);
        check("wr_ram_write", ram_write[0], 1'b1);
        check("wr_ram_addr", ram_addr[0], 16'h0004);
        check("wr_ram_wdata", ram_wdata[0], 16'hBEEF);
        req[0] = 2'b00; write[0] = 2'b00;
        @(negedge clock);
        check("wr_ram_en_drop", ram_en[0], 1'b0);
        check("wr_gnt_drop", gnt[0], 2'b00);

        // CPU read of 0004, RD_LATENCY=1: rvalid[1] two cycles after gnt
        req[0] = 2'b10; addr[0][31:16] = 16'h0004;
        @(negedge clock);
        check("rd_gnt", gnt[0], 2'b10);
        check("rd_ram_en", ram_en[0], 1'b1);
        check("rd_ram_write", ram_write[0], 1'b0);
        check("rd_ram_addr", ram_addr[0], 16'h0004);
        req[0] = 2'b00;
        @(negedge clock);
        check("rd_rvalid_early", rvalid[0], 2'b00);
        @(negedge clock);
        check("rd_rvalid", rvalid[0], 2'b10);
        check("rd_rdata", rdata[0], 16'hBEEF);
        @(negedge clock);
        check("rd_rvalid_pulse", rvalid[0], 2'b00);
        check("rd_rdata_hold", rdata[0], 16'hBEEF);

        // Both hold req continuously: grants alternate loader, CPU, loader, CPU
        req[0] = 2'b11; write[0] = 2'b11;
        addr[0] = {16'h0020, 16'h0010}; wdata[0] = {16'h2222, 16'h1111};
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check($sformatf("alt_gnt%0d", k), gnt[0], exp_g[k]);
            if (k == 0) check("alt_addr_ld", ram_addr[0], 16'h0010);
            if (k == 2) check("alt_addr_cpu", ram_addr[0], 16'h0020);
        end
        req[0] = 2'b00; write[0] = 2'b00;

`ifdef MEM_ARB_STATS_EN
        // Grants so far: loader 3, CPU 3; IDLE cycles with both requesting: 4
        repeat (2) @(negedge clock);
        check("st_gnt0", gnt_count0[0], 16'd3);
        check("st_gnt1", gnt_count1[0], 16'd3);
        check("st_conflict", conflict_count[0], 16'd4);
        force dut0.u_stats.gnt_count0_q = 16'hFFFF;
        @(negedge clock);
        release dut0.u_stats.gnt_count0_q;
        req[0] = 2'b01; write[0] = 2'b01;
        @(negedge clock);
        check("st_sat_gnt", gnt[0], 2'b01);
        req[0] = 2'b00; write[0] = 2'b00;
        repeat (2) @(negedge clock);
        check("st_sat", gnt_count0[0], 16'hFFFF);
        check("st_gnt1_keep", gnt_count1[0], 16'd3);
`endif

        // Instance 1 (RD_LATENCY=4): loader write 0008 <- CAFE
        req[1] = 2'b01; write[1] = 2'b01; addr[1][15:0] = 16'h0008; wdata[1][15:0] = 16'hCAFE;
        @(negedge clock);
        check("l4_wr_gnt", gnt[1], 2'b01);
        req[1] = 2'b00; write[1] = 2'b00;
        @(negedge clock);

        // CPU read 0008: rvalid exactly 5 cycles after gnt; loader req raised in RD_WAIT
        req[1] = 2'b10; addr[1][31:16] = 16'h0008;
        @(negedge clock);
        check("l4_rd_gnt", gnt[1], 2'b10);
        req[1] = 2'b00;
        @(negedge clock);
        req[1] = 2'b01; write[1] = 2'b01; addr[1][15:0] = 16'h0009; wdata[1][15:0] = 16'h1234;
        check("l4_rv_early2", rvalid[1], 2'b00);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clock);
            check($sformatf("l4_rv_early%0d", k), rvalid[1], 2'b00);
            check($sformatf("l4_gnt_wait%0d", k), gnt[1], 2'b00);
        end
        @(negedge clock);
        check("l4_rvalid", rvalid[1], 2'b10);
        check("l4_rdata", rdata[1], 16'hCAFE);
        check("l4_gnt_at_rv", gnt[1], 2'b00);
        @(negedge clock);
        check("l4_ld_gnt", gnt[1], 2'b01);
        check("l4_rvalid_pulse", rvalid[1], 2'b00);
        check("l4_ld_addr", ram_addr[1], 16'h0009);
        req[1] = 2'b00; write[1] = 2'b00;
        @(negedge clock);

        // Loader read, reset asserted during RD_WAIT
        req[1] = 2'b01; write[1] = 2'b00; addr[1][15:0] = 16'h0008;
        @(negedge clock);
        check("ra_gnt", gnt[1], 2'b01);
        req[1] = 2'b00;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("ra_gnt0", gnt[1], 2'b00);
        check("ra_rvalid0", rvalid[1], 2'b00);
        check("ra_ram_en0", ram_en[1], 1'b0);
        check("ra_ram_addr0", ram_addr[1], 16'h0);
        check("ra_ram_wdata0", ram_wdata[1], 16'h0);
        check("ra_rdata0", rdata[1], 16'h0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check($sformatf("ra_no_rv%0d", k), rvalid[1], 2'b00);
        end

        // After reset the loader wins the first tie again
        req[1] = 2'b11; write[1] = 2'b11;
        addr[1] = {16'h0040, 16'h0030}; wdata[1] = {16'h4444, 16'h3333};
        @(negedge clock);
        check("ra_tie_gnt", gnt[1], 2'b01);
        check("ra_tie_addr", ram_addr[1], 16'h0030);
        req[1] = 2'b10;
        @(negedge clock);
        check("ra_tie_gap", gnt[1], 2'b00);
        @(negedge clock);
        check("ra_tie_cpu", gnt[1], 2'b10);
        check("ra_tie_cpu_addr", ram_addr[1], 16'h0040);
        req[1] = 2'b00; write[1] = 2'b00;
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port system RAM between the program loader (requester 0) and the CPU (requester 1). Arbitration is round-robin and allows one outstanding transaction at a time. Reads have a programmable latency. The block sits inside system between loader/cpu and ram, replacing direct muxing on system_state, so that loading and execution can overlap (e.g. a debug reload while halted).

Parameters:
ADDR_W, 16, address width of RAM and requesters
DATA_W, 16, data word width
RD_LATENCY, 1, cycles from ram_en (read) to valid ram_rdata; legal range 1..8

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req  in  2  per-requester request; bit0 loader, bit1 cpu; held until gnt
write  in  2  per-requester 1=write, 0=read; held with req
addr  in  2*ADDR_W  per-requester address; requester n at [n*ADDR_W +: ADDR_W]
wdata  in  2*DATA_W  per-requester write data, same packing
gnt  out  2  one-hot, one-cycle pulse: request accepted
rvalid  out  2  one-hot, one-cycle pulse: rdata valid for that requester
rdata  out  DATA_W  read data, broadcast; qualified by rvalid
ram_en  out  1  RAM access strobe, one cycle per transaction
ram_write  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid RD_LATENCY cycles after ram_en

Behaviour:
- Reset (reset==0, asynchronous) sets state IDLE; gnt, rvalid, ram_en and ram_write to 0; ram_addr, ram_wdata and rdata to 0; last_winner=1 (loader wins first tie); latency counter to 0.
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE: sample req. If none, stay. If one, it wins. If both, the requester != last_winner wins. On the edge, register winner's addr/wdata/write onto ram_*, set ram_en=1, set gnt[winner]=1, update last_winner, go to ISSUE.
- ISSUE (one cycle; ram_en and gnt visible):
  - next edge clears ram_en/gnt.
  - write -> IDLE.
  - read -> RD_WAIT, counter=RD_LATENCY-1.
- RD_WAIT: decrement counter each cycle. When it is 0, capture ram_rdata into rdata, pulse rvalid[owner] for one cycle, and go to IDLE.
  - With RD_LATENCY=1, rvalid is asserted 2 cycles after gnt.
- Latency from req (IDLE) to gnt is 1 cycle. A write occupies 2 cycles; a read occupies 2+RD_LATENCY cycles.
- Requester protocol:
  - Drop req on the edge where gnt is sampled high, unless a further transaction is wanted. The held-high req is re-arbitrated in the following IDLE.
  - req/addr/write/wdata changes while not granted are legal; the value sampled in IDLE wins.
- A request from the non-owner during ISSUE/RD_WAIT is not lost; it is arbitrated in the next IDLE and is guaranteed to win a tie there (round-robin, no starvation).
- rdata holds its last captured value between rvalid pulses.
- Reset mid-transaction: the transaction is aborted, no rvalid is issued, and the requester must re-request. A RAM write already strobed is not undone.

Optional Feature:
MEM_ARB_STATS_EN: when defined, adds outputs gnt_count0 [15:0], gnt_count1 [15:0] and conflict_count [15:0].
- gnt_count0/gnt_count1 increment on each gnt pulse of the respective requester.
- conflict_count increments in each IDLE cycle where req==2'b11.
- All three saturate at 16'hFFFF and clear on reset.
When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
Package mem_arb_pkg holds:
- state encoding IDLE=2'd0, ISSUE=2'd1, RD_WAIT=2'd2
- requester IDs REQ_LOADER=0, REQ_CPU=1
- latency counter width constant (3 bits, covers 1..8)
One sub-module, mem_arb_stats: the three saturating counters, instantiated only under MEM_ARB_STATS_EN.

Test Plan:
- Reset, then loader writes addr 16'h0004 data 16'hBEEF -> gnt[0] 1 cycle after req; ram_en=1, ram_write=1, ram_addr=0004, ram_wdata=BEEF for exactly one cycle.
- CPU read of addr 0004 after the above, RD_LATENCY=1 -> rvalid[1] 2 cycles after gnt[1], rdata=BEEF; rvalid[0] stays 0.
- Both request in the same IDLE cycle after reset -> loader granted first, CPU granted in the next IDLE. Both hold req continuously -> grants alternate 0,1,0,1.
- RD_LATENCY=4 read -> rvalid exactly 5 cycles after gnt; a loader req raised during RD_WAIT is granted 1 cycle after the read's rvalid.
- reset asserted in RD_WAIT -> outputs 0 immediately (asynchronously), no rvalid afterwards, last_winner=1.
- With MEM_ARB_STATS_EN: 3 loader writes, 2 CPU reads, 1 conflict -> gnt_count0=3, gnt_count1=2, conflict_count=1; forcing 16'hFFFF then one more grant leaves 16'hFFFF.
